// File: rtl/codec_i2c_pkg.sv
// Shared definitions for the codec I2C write sequencer.
// Latency: n/a (types, constants and a pure line-drive decode).
// Backpressure: n/a.
package codec_i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BIT,
      ST_ACK,
      ST_STOP
   } state_t;

   localparam int   BITS_PER_BYTE     = 8;
   localparam int   NUM_BYTES         = 3;
   localparam int   QUARTERS_PER_SLOT = 4;
   localparam logic WRITE_BIT         = 1'b0;

   // Pad drive for a given slot and quarter, returned as {scl_oe, sda_oe}.
   // A 1 pulls the line low; bit_val is the data bit for BIT slots.
   function automatic logic [1:0] line_drive(input state_t     st,
                                             input logic [1:0] qtr,
                                             input logic       bit_val);
      logic scl_low;
      scl_low    = (qtr == 2'd0) || (qtr == 2'd3);
      line_drive = 2'b00;
      case (st)
         ST_START: line_drive = {1'b0, qtr[1]};
         ST_BIT:   line_drive = {scl_low, ~bit_val};
         ST_ACK:   line_drive = {scl_low, 1'b0};
         ST_STOP:  line_drive = {(qtr == 2'd0), ~qtr[1]};
         default:  line_drive = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period tick generator: counts 0..CLK_DIV-1 while enabled.
// Latency: o_tick is combinational on the last count, one cycle wide every CLK_DIV enabled cycles.
// Backpressure: none; i_clr restarts the count, i_en low freezes it.
module i2c_quarter_tick #(
   parameter int CLK_DIV = 250
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tick
);

   localparam int             CW   = $clog2(CLK_DIV);
   localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   // Free count within a quarter, wrapping at CLK_DIV-1, held when disabled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else if (i_clr) begin
         cnt <= '0;
      end else if (i_en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign o_tick = i_en && (cnt == LAST);

endmodule

// File: rtl/codec_i2c_writer.sv
// I2C master issuing one START / dev+W / reg / data / STOP write to the codec.
// Latency: 116*CLK_DIV cycles accept-to-done when all bytes ACK; a NACK jumps straight to STOP.
// Backpressure: i_start is honoured only in IDLE; requests while o_busy are dropped.
module codec_i2c_writer
   import codec_i2c_pkg::*;
#(
   parameter int CLK_DIV = 250
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic [6:0] i_dev_addr,
   input  logic [7:0] i_reg_addr,
   input  logic [7:0] i_data,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_ack_err,
   output logic       o_scl_oe,
   output logic       o_sda_oe,
   input  logic       i_sda
);

   localparam int         SW       = NUM_BYTES * BITS_PER_BYTE;
   localparam logic [1:0] Q_LAST   = 2'(QUARTERS_PER_SLOT - 1);
   localparam logic [2:0] BIT_MSB  = 3'(BITS_PER_BYTE - 1);
   localparam logic [1:0] BYTE_END = 2'(NUM_BYTES - 1);

   state_t        state;
   logic [1:0]    qtr;
   logic [2:0]    bit_idx;
   logic [1:0]    byte_idx;
   logic [SW-1:0] shadow;   // outgoing bits, MSB is always the bit on the wire
   logic          tick;
   logic          accept;

   assign accept = (state == ST_IDLE) && i_start;

   i2c_quarter_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (accept),
      .i_en    (o_busy),
      .o_tick  (tick)
   );

   // Slot/quarter sequencer; pad drives are registered from the slot being entered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         qtr       <= 2'd0;
         bit_idx   <= BIT_MSB;
         byte_idx  <= 2'd0;
         shadow    <= '0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_ack_err <= 1'b0;
         o_scl_oe  <= 1'b0;
         o_sda_oe  <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (state == ST_IDLE) begin
            if (i_start) begin
               shadow    <= {i_dev_addr, WRITE_BIT, i_reg_addr, i_data};
               o_ack_err <= 1'b0;
               o_busy    <= 1'b1;
               qtr       <= 2'd0;
               state     <= ST_START;
               {o_scl_oe, o_sda_oe} <= line_drive(ST_START, 2'd0, 1'b1);
            end
         end else if (tick) begin
            if (qtr != Q_LAST) begin
               // Within a slot: advance the quarter; the slave's ACK is read as SCL-high ends.
               if (state == ST_ACK && qtr == 2'd2 && i_sda) begin
                  o_ack_err <= 1'b1;
               end
               qtr <= qtr + 2'd1;
               {o_scl_oe, o_sda_oe} <= line_drive(state, qtr + 2'd1, shadow[SW-1]);
            end else begin
               qtr <= 2'd0;
               case (state)
                  ST_START: begin
                     state    <= ST_BIT;
                     bit_idx  <= BIT_MSB;
                     byte_idx <= 2'd0;
                     {o_scl_oe, o_sda_oe} <= line_drive(ST_BIT, 2'd0, shadow[SW-1]);
                  end
                  ST_BIT: begin
                     shadow <= {shadow[SW-2:0], 1'b0};
                     if (bit_idx == 3'd0) begin
                        state <= ST_ACK;
                        {o_scl_oe, o_sda_oe} <= line_drive(ST_ACK, 2'd0, 1'b1);
                     end else begin
                        bit_idx <= bit_idx - 3'd1;
                        {o_scl_oe, o_sda_oe} <= line_drive(ST_BIT, 2'd0, shadow[SW-2]);
                     end
                  end
                  ST_ACK: begin
                     // A NACK abandons the remaining bytes.
                     if (o_ack_err || byte_idx == BYTE_END) begin
                        state <= ST_STOP;
                        {o_scl_oe, o_sda_oe} <= line_drive(ST_STOP, 2'd0, 1'b1);
                     end else begin
                        state    <= ST_BIT;
                        byte_idx <= byte_idx + 2'd1;
                        bit_idx  <= BIT_MSB;
                        {o_scl_oe, o_sda_oe} <= line_drive(ST_BIT, 2'd0, shadow[SW-1]);
                     end
                  end
                  default: begin
                     state    <= ST_IDLE;
                     o_busy   <= 1'b0;
                     o_done   <= 1'b1;
                     o_scl_oe <= 1'b0;
                     o_sda_oe <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_codec_i2c_writer.sv
// Scoreboarded bench for codec_i2c_writer with a bus-level slave/monitor.
// Latency: expectations derive from slot counts (START + 9-slot bytes + STOP).
// Backpressure: stimulus only issues a start when the DUT reports idle.
module tb_codec_i2c_writer;

   localparam int CLK_DIV = 4;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_start = 1'b0;
   logic [6:0] i_dev_addr = 7'h0;
   logic [7:0] i_reg_addr = 8'h0;
   logic [7:0] i_data = 8'h0;
   logic       o_busy, o_done, o_ack_err, o_scl_oe, o_sda_oe;
   logic       i_sda;
   logic       slave_pull = 1'b0;

   // Open-drain wired-AND of master and slave on SDA.
   assign i_sda = ~o_sda_oe & ~slave_pull;

   always #5 i_clk = ~i_clk;

   codec_i2c_writer #(.CLK_DIV(CLK_DIV)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_start    (i_start),
      .i_dev_addr (i_dev_addr),
      .i_reg_addr (i_reg_addr),
      .i_data     (i_data),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_ack_err  (o_ack_err),
      .o_scl_oe   (o_scl_oe),
      .o_sda_oe   (o_sda_oe),
      .i_sda      (i_sda)
   );

   typedef struct packed {
      logic [23:0] bytes;
      int          nbytes;
      logic        ack_err;
      int          latency;
      int          nack_byte;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] got[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         done_cnt = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: what the bus should carry for a write whose slave NACKs byte nack (>=3: none).
   function automatic exp_t model(input logic [6:0] dev, input logic [7:0] ra,
                                  input logic [7:0] d, input int nack);
      exp_t e;
      int   n;
      n           = (nack < 3) ? nack + 1 : 3;
      e.bytes     = {8'(dev * 2), ra, d};
      e.nbytes    = n;
      e.ack_err   = (nack < 3);
      e.latency   = CLK_DIV * (4 + 9 * 4 * n + 4);
      e.nack_byte = nack;
      return e;
   endfunction

   // Bus monitor + slave: decodes START/STOP/bytes, ACKs per expectation, scores on o_done.
   initial begin : monitor
      logic       prev_scl, prev_sda, prev_busy, scl, sda, start_seen, stop_seen;
      logic [7:0] sh;
      int         nbits, acc_cyc;
      exp_t       e;
      prev_scl = 1'b1; prev_sda = 1'b1; prev_busy = 1'b0;
      start_seen = 1'b0; stop_seen = 1'b0; sh = 8'h0; nbits = 0; acc_cyc = 0;
      forever begin
         @(negedge i_clk);
         scl = ~o_scl_oe;
         sda = i_sda;
         if (!i_rst_n) begin
            got.delete();
            nbits = 0; start_seen = 1'b0; stop_seen = 1'b0; slave_pull = 1'b0;
         end else begin
            if (o_busy && !prev_busy) acc_cyc = cyc;
            if (prev_scl && scl && prev_sda && !sda) begin
               start_seen = 1'b1; got.delete(); nbits = 0;
            end
            if (prev_scl && scl && !prev_sda && sda) stop_seen = 1'b1;
            if (!prev_scl && scl) begin
               if (nbits < 8) begin
                  sh = {sh[6:0], sda};
                  nbits++;
                  if (nbits == 8) got.push_back(sh);
               end else begin
                  nbits = 0;
               end
            end
            if (prev_scl && !scl) begin
               slave_pull = (nbits == 8) &&
                            !(sb_q.size() > 0 && (got.size() - 1) == sb_q[0].nack_byte);
            end
            if (o_done) begin
               done_cnt++;
               if (sb_q.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  logic [23:0] w;
                  e = sb_q.pop_front();
                  w = e.bytes;
                  check("byte_count", got.size(), e.nbytes);
                  for (int i = 0; i < 3; i++) begin
                     if (i < e.nbytes && i < got.size())
                        check($sformatf("byte%0d", i), {24'h0, got[i]}, {24'h0, w[23-8*i -: 8]});
                  end
                  check("start_seen", start_seen, 1'b1);
                  check("stop_seen", stop_seen, 1'b1);
                  check("ack_err", o_ack_err, e.ack_err);
                  check("latency", cyc - acc_cyc, e.latency);
                  check("busy_at_done", o_busy, 1'b0);
               end
               start_seen = 1'b0; stop_seen = 1'b0;
            end
         end
         prev_scl = scl; prev_sda = sda; prev_busy = o_busy;
      end
   end

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      @(negedge i_clk);
      while (o_busy && n < max) begin
         @(negedge i_clk);
         n++;
      end
      check("idle_timeout", o_busy, 1'b0);
   endtask

   // Present a request at a negedge while idle, then scramble the inputs after accept.
   task automatic issue(input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] d,
                        input int nack);
      wait_idle(2000);
      i_dev_addr = dev; i_reg_addr = ra; i_data = d; i_start = 1'b1;
      sb_q.push_back(model(dev, ra, d, nack));
      @(negedge i_clk);
      i_start    = 1'b0;
      i_dev_addr = 7'($urandom);
      i_reg_addr = 8'($urandom);
      i_data     = 8'($urandom);
   endtask

   initial begin : stimulus
      int d0, n;
      i_rst_n = 1'b1;
      #2 i_rst_n = 1'b0;
      #1;
      check("rst_busy", o_busy, 1'b0);
      check("rst_done", o_done, 1'b0);
      check("rst_ack_err", o_ack_err, 1'b0);
      check("rst_scl_oe", o_scl_oe, 1'b0);
      check("rst_sda_oe", o_sda_oe, 1'b0);
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;

      // Nominal write and NACK on the address byte.
      issue(7'h1A, 8'h0C, 8'h5A, 3);
      issue(7'h1A, 8'h0C, 8'h5A, 0);

      // A start during an active transaction must be ignored.
      issue(7'h1A, 8'h0C, 8'h5A, 3);
      repeat (99) @(negedge i_clk);
      d0 = done_cnt;
      i_dev_addr = 7'h55; i_reg_addr = 8'hF0; i_data = 8'h0F; i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      wait_idle(2000);
      @(posedge i_clk);
      check("single_done", done_cnt - d0, 1);

      // Asynchronous reset mid-transaction, then a clean transaction.
      issue(7'h3C, 8'hA5, 8'hC3, 3);
      repeat (198) @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      check("arst_scl_oe", o_scl_oe, 1'b0);
      check("arst_sda_oe", o_sda_oe, 1'b0);
      check("arst_busy", o_busy, 1'b0);
      sb_q.delete();
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      issue(7'h2B, 8'h11, 8'hEE, 3);

      // Back-to-back with i_start held: NACKed write followed by a clean one.
      wait_idle(2000);
      i_dev_addr = 7'h10; i_reg_addr = 8'h22; i_data = 8'h33; i_start = 1'b1;
      sb_q.push_back(model(7'h10, 8'h22, 8'h33, 0));
      n = 0;
      @(negedge i_clk);
      while (!o_done && n < 2000) begin
         @(negedge i_clk);
         n++;
      end
      check("b2b_done_timeout", o_done, 1'b1);
      i_dev_addr = 7'h44; i_reg_addr = 8'h55; i_data = 8'h66;
      sb_q.push_back(model(7'h44, 8'h55, 8'h66, 3));
      @(negedge i_clk);
      check("b2b_accept", o_busy, 1'b1);
      check("b2b_err_clear", o_ack_err, 1'b0);
      i_start = 1'b0;

      // Randomized writes with random NACK positions.
      for (int t = 0; t < 10; t++) begin
         int nk;
         nk = $urandom_range(0, 5);
         issue(7'($urandom), 8'($urandom), 8'($urandom), nk);
         repeat ($urandom_range(0, 5)) @(negedge i_clk);
      end

      wait_idle(2000);
      @(posedge i_clk);
      check("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
